// File: rtl/z80_bus_target.sv
// Z80 bus target: turns CPU memory/I/O strobes into a held request/ack
// handshake towards a backing store, stretching the CPU with WAIT until done.
module z80_bus_target #(
   parameter logic [7:0]  IO_PAGE    = 8'h10,
   parameter int unsigned EXTRA_WAIT = 0,
   parameter logic [7:0]  INTA_VEC   = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_mreq_n,
   input  logic        cpu_iorq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic        cpu_m1_n,
   input  logic        cpu_rfsh_n,
   output logic [7:0]  cpu_di,
   output logic        cpu_wait_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_XWAIT,
      S_DONE
   } state_t;

   localparam bit         HAS_XWAIT = (EXTRA_WAIT != 0);
   localparam logic [3:0] XW_LAST   = HAS_XWAIT ? 4'(EXTRA_WAIT - 1) : 4'd0;

   state_t      state_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic [7:0]  cpu_di_q;
   logic [3:0]  cnt_q;
   logic        rel_q;

   logic        is_memrd;
   logic        is_memwr;
   logic        is_iord;
   logic        is_iowr;
   logic        is_inta;
   logic        is_mem;
   logic        acc_act;
   logic        released;
   logic        rel_d;
   logic        we_d;
   logic [15:0] addr_d;

   always_comb begin
      is_memrd = !cpu_mreq_n && !cpu_rd_n && cpu_rfsh_n;
      is_memwr = !cpu_mreq_n && !cpu_wr_n;
      is_iord  = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n;
      is_iowr  = !cpu_iorq_n && !cpu_wr_n;
      is_inta  = !cpu_iorq_n && !cpu_m1_n;
      is_mem   = is_memrd || is_memwr;
      // Refresh never matches a read/write type, so it is naturally excluded here.
      acc_act  = (is_mem || is_iord || is_iowr) && !is_inta;
      released = (cpu_rd_n && cpu_wr_n) || (cpu_mreq_n && cpu_iorq_n);
      rel_d    = rel_q || released;
      we_d     = is_mem ? is_memwr : is_iowr;
      addr_d   = is_mem ? cpu_a : {IO_PAGE, cpu_a[7:0]};
   end

   always_comb begin
      cpu_wait_n = !(acc_act && (state_q != S_DONE));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_di_q    <= '1;
         cnt_q       <= '0;
         rel_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_inta) begin
                  cpu_di_q <= INTA_VEC;
                  state_q  <= S_DONE;
               end else if (acc_act) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= we_d;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= cpu_do;
                  rel_q       <= 1'b0;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               // A strobe release here is remembered so completion skips DONE.
               rel_q <= rel_d;
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= '0;
                  if (!mem_we_q) begin
                     cpu_di_q <= mem_rdata;
                  end
                  if (HAS_XWAIT) begin
                     state_q <= S_XWAIT;
                  end else begin
                     state_q <= rel_d ? S_IDLE : S_DONE;
                  end
               end
            end
            S_XWAIT: begin
               rel_q <= rel_d;
               if (cnt_q == XW_LAST) begin
                  state_q <= rel_d ? S_IDLE : S_DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_DONE: begin
               if (released) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_di    = cpu_di_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Scoreboard bench for z80_bus_target: default instance plus one with
// EXTRA_WAIT=2 and a distinct interrupt vector, sharing the CPU-side stimulus.
module tb_z80_bus_target;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = '0;
   logic [7:0]  dout = '0;
   logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
   logic        m1_n = 1'b1, rfsh_n = 1'b1;
   logic [7:0]  rdata = '0;
   logic        ack = 1'b0;

   logic [7:0]  di1, di2;
   logic        wait1, wait2, req1, req2, we1, we2;
   logic [15:0] addr1, addr2;
   logic [7:0]  wdata1, wdata2;

   int   tests = 0;
   int   fails = 0;
   int   req_count = 0;
   exp_t exp_q[$];
   exp_t cur;
   logic req1_prev = 1'b0;

   always #5 clk = ~clk;

   z80_bus_target dut1 (
      .clk(clk), .reset_n(rst_n), .cpu_a(a), .cpu_do(dout),
      .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n), .cpu_rd_n(rd_n), .cpu_wr_n(wr_n),
      .cpu_m1_n(m1_n), .cpu_rfsh_n(rfsh_n), .cpu_di(di1), .cpu_wait_n(wait1),
      .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
      .mem_rdata(rdata), .mem_ack(ack)
   );

   z80_bus_target #(.EXTRA_WAIT(2), .INTA_VEC(8'hA5)) dut2 (
      .clk(clk), .reset_n(rst_n), .cpu_a(a), .cpu_do(dout),
      .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n), .cpu_rd_n(rd_n), .cpu_wr_n(wr_n),
      .cpu_m1_n(m1_n), .cpu_rfsh_n(rfsh_n), .cpu_di(di2), .cpu_wait_n(wait2),
      .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
      .mem_rdata(rdata), .mem_ack(ack)
   );

   // Request monitor on dut1: pops the scoreboard at each new request and
   // checks the request fields stay frozen while mem_req is high.
   always @(negedge clk) begin
      if (req1 && !req1_prev) begin
         req_count++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_req: got addr=%h we=%b, required no request", addr1, we1);
         end else begin
            cur = exp_q.pop_front();
            if (we1 !== cur.we || addr1 !== cur.addr || (cur.we && wdata1 !== cur.wdata)) begin
               fails++;
               $display("FAIL req_fields: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                        we1, addr1, wdata1, cur.we, cur.addr, cur.wdata);
            end
         end
      end else if (req1 && req1_prev) begin
         tests++;
         if (we1 !== cur.we || addr1 !== cur.addr || (cur.we && wdata1 !== cur.wdata)) begin
            fails++;
            $display("FAIL req_stable: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     we1, addr1, wdata1, cur.we, cur.addr, cur.wdata);
         end
      end
      req1_prev = req1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      m1_n = 1'b1; rfsh_n = 1'b1; ack = 1'b0;
   endtask

   task automatic do_reset();
      bus_idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus_idle();
      rst_n = 1'b0;
      tick();
      tick();
      #1;
      tests++;
      if (req1 !== 1'b0 || we1 !== 1'b0 || addr1 !== 16'h0000 || wdata1 !== 8'h00) begin
         fails++;
         $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h, required all zero", req1, we1, addr1, wdata1);
      end
      tests++;
      if (di1 !== 8'hFF || wait1 !== 1'b1) begin
         fails++;
         $display("FAIL reset_cpu: got di=%h wait_n=%b, required di=ff wait_n=1", di1, wait1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_memrd();
      int wlow;
      do_reset();
      a = 16'h43F7; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back('{we: 1'b0, addr: 16'h43F7, wdata: 8'h00});
      wlow = 0;
      for (int c = 0; c <= 4; c++) begin
         if (c == 3) begin ack = 1'b1; rdata = 8'hE9; end
         else ack = 1'b0;
         #1;
         if (wait1 === 1'b0) wlow++;
         if (c == 4) begin
            tests++;
            if (req1 !== 1'b0 || di1 !== 8'hE9) begin
               fails++;
               $display("FAIL memrd_done: got req=%b di=%h, required req=0 di=e9", req1, di1);
            end
         end
         if (c < 4) tick();
      end
      tests++;
      if (wlow != 4) begin
         fails++;
         $display("FAIL memrd_wait_len: got %0d low cycles, required 4", wlow);
      end
      bus_idle();
      tick();
      tests++;
      if (di1 !== 8'hE9 || wait1 !== 1'b1) begin
         fails++;
         $display("FAIL memrd_hold: got di=%h wait_n=%b, required di=e9 wait_n=1", di1, wait1);
      end
   endtask

   task automatic test_iowr();
      int r0;
      do_reset();
      r0 = req_count;
      a = 16'hAB55; dout = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
      exp_q.push_back('{we: 1'b1, addr: 16'h1055, wdata: 8'h5A});
      tick();
      ack = 1'b1;
      #1;
      tests++;
      if (req1 !== 1'b1 || we1 !== 1'b1 || addr1 !== 16'h1055 || wdata1 !== 8'h5A) begin
         fails++;
         $display("FAIL iowr_req: got req=%b we=%b addr=%h wdata=%h, required 1 1 1055 5a", req1, we1, addr1, wdata1);
      end
      tick();
      ack = 1'b0;
      tick();
      tick();
      #1;
      tests++;
      if (req1 !== 1'b0 || wait1 !== 1'b1 || req_count - r0 != 1) begin
         fails++;
         $display("FAIL iowr_once: got req=%b wait_n=%b reqs=%0d, required 0 1 1", req1, wait1, req_count - r0);
      end
      bus_idle();
      tick();
   endtask

   task automatic test_extra_wait();
      do_reset();
      a = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'h00});
      tick();
      ack = 1'b1; rdata = 8'h3C;
      tick();
      ack = 1'b0;
      #1;
      tests++;
      if (wait1 !== 1'b1 || wait2 !== 1'b0) begin
         fails++;
         $display("FAIL xw_ack1: got wait_n0=%b wait_n2=%b, required 1 0", wait1, wait2);
      end
      tick();
      #1;
      tests++;
      if (wait2 !== 1'b0) begin
         fails++;
         $display("FAIL xw_ack2: got wait_n2=%b, required 0", wait2);
      end
      tick();
      #1;
      tests++;
      if (wait2 !== 1'b1 || di2 !== 8'h3C || req2 !== 1'b0) begin
         fails++;
         $display("FAIL xw_ack3: got wait_n2=%b di=%h req=%b, required 1 3c 0", wait2, di2, req2);
      end
      bus_idle();
      tick();
   endtask

   task automatic test_refresh_inta();
      int r0;
      do_reset();
      r0 = req_count;
      mreq_n = 1'b0; rfsh_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (wait1 !== 1'b1 || req1 !== 1'b0) begin
            fails++;
            $display("FAIL refresh_c%0d: got wait_n=%b req=%b, required 1 0", c, wait1, req1);
         end
         tick();
      end
      bus_idle();
      tick();
      iorq_n = 1'b0; m1_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (wait1 !== 1'b1 || wait2 !== 1'b1 || req1 !== 1'b0 || di1 !== 8'hFF) begin
            fails++;
            $display("FAIL inta_c%0d: got wait_n=%b/%b req=%b di=%h, required 1/1 0 ff", c, wait1, wait2, req1, di1);
         end
         tick();
      end
      tests++;
      if (di2 !== 8'hA5 || req2 !== 1'b0) begin
         fails++;
         $display("FAIL inta_vec: got di=%h req=%b, required a5 0", di2, req2);
      end
      bus_idle();
      tick();
      tests++;
      if (req_count - r0 != 0) begin
         fails++;
         $display("FAIL refresh_inta_reqs: got %0d requests, required 0", req_count - r0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      a = 16'hBEEF; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back('{we: 1'b0, addr: 16'hBEEF, wdata: 8'h00});
      tick();
      rst_n = 1'b0;
      tick();
      #1;
      tests++;
      if (req1 !== 1'b0 || di1 !== 8'hFF || addr1 !== 16'h0000) begin
         fails++;
         $display("FAIL rstmid_req: got req=%b di=%h addr=%h, required 0 ff 0000", req1, di1, addr1);
      end
      rst_n = 1'b1;
      bus_idle();
      ack = 1'b1; rdata = 8'h77;
      tick();
      ack = 1'b0;
      tick();
      #1;
      tests++;
      if (req1 !== 1'b0 || di1 !== 8'hFF || wait1 !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_late_ack: got req=%b di=%h wait_n=%b, required 0 ff 1", req1, di1, wait1);
      end
   endtask

   task automatic test_back_to_back();
      int r0;
      do_reset();
      r0 = req_count;
      for (int f = 0; f < 2; f++) begin
         a = 16'(f); mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
         exp_q.push_back('{we: 1'b0, addr: 16'(f), wdata: 8'h00});
         tick();
         ack = 1'b1; rdata = 8'hC0 + 8'(f);
         tick();
         ack = 1'b0;
         tick();
         tick();
         #1;
         tests++;
         if (di1 !== 8'hC0 + 8'(f) || wait1 !== 1'b1) begin
            fails++;
            $display("FAIL fetch%0d: got di=%h wait_n=%b, required %h 1", f, di1, wait1, 8'hC0 + 8'(f));
         end
         bus_idle();
         tick();
      end
      tests++;
      if (req_count - r0 != 2) begin
         fails++;
         $display("FAIL fetch_count: got %0d requests, required 2", req_count - r0);
      end
   endtask

   task automatic test_rd_to_wr();
      int r0;
      do_reset();
      r0 = req_count;
      a = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back('{we: 1'b0, addr: 16'h2000, wdata: 8'h00});
      tick();
      ack = 1'b1; rdata = 8'h11;
      tick();
      ack = 1'b0; rd_n = 1'b1; wr_n = 1'b0; dout = 8'h99;
      tick();
      tick();
      #1;
      tests++;
      if (req1 !== 1'b0 || wait1 !== 1'b1 || req_count - r0 != 1) begin
         fails++;
         $display("FAIL rd_to_wr: got req=%b wait_n=%b reqs=%0d, required 0 1 1", req1, wait1, req_count - r0);
      end
      bus_idle();
      tick();
   endtask

   task automatic test_release_in_req();
      do_reset();
      a = 16'h5555; mreq_n = 1'b0; rd_n = 1'b0;
      exp_q.push_back('{we: 1'b0, addr: 16'h5555, wdata: 8'h00});
      tick();
      bus_idle();
      tick();
      #1;
      tests++;
      if (req1 !== 1'b1 || wait1 !== 1'b1) begin
         fails++;
         $display("FAIL rel_nocancel: got req=%b wait_n=%b, required 1 1", req1, wait1);
      end
      ack = 1'b1; rdata = 8'hC3;
      tick();
      ack = 1'b0;
      a = 16'h6666; dout = 8'h42; mreq_n = 1'b0; wr_n = 1'b0;
      exp_q.push_back('{we: 1'b1, addr: 16'h6666, wdata: 8'h42});
      #1;
      tests++;
      if (req1 !== 1'b0 || di1 !== 8'hC3 || wait1 !== 1'b0) begin
         fails++;
         $display("FAIL rel_complete: got req=%b di=%h wait_n=%b, required 0 c3 0", req1, di1, wait1);
      end
      tick();
      ack = 1'b1;
      #1;
      tests++;
      if (req1 !== 1'b1) begin
         fails++;
         $display("FAIL rel_next_req: got req=%b, required 1", req1);
      end
      tick();
      ack = 1'b0;
      bus_idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_memrd();
      test_iowr();
      test_extra_wait();
      test_refresh_inta();
      test_reset_mid();
      test_back_to_back();
      test_rd_to_wr();
      test_release_in_req();
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/z80_bus_target.md
Z80_BUS_TARGET -- requirements
Module: z80_bus_target

Interface
REQ-001 SHALL have parameter IO_PAGE, default 8'h10, upper address byte used for I/O cycles.
REQ-002 SHALL have parameter EXTRA_WAIT, default 0, range 0-15, added wait cycles after mem_ack.
REQ-003 SHALL have parameter INTA_VEC, default 8'hFF, byte driven during interrupt acknowledge.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 cpu_a  in  16  CPU address bus.
REQ-007 cpu_do  in  8  CPU write data.
REQ-008 cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n  in  1 each  CPU strobes, active-low.
REQ-009 cpu_di  out  8  read data to CPU.
REQ-010 cpu_wait_n  out  1  wait request to CPU, active-low.
REQ-011 mem_req  out  1  backing-store request, held until mem_ack.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  out  16  access address; valid while mem_req=1.
REQ-014 mem_wdata  out  8  write data; valid while mem_req=1.
REQ-015 mem_rdata  in  8  read data; valid in the mem_ack cycle.
REQ-016 mem_ack  in  1  one-cycle completion pulse; ignored while mem_req=0.

Function
REQ-017 SHALL implement states IDLE, REQ, XWAIT, DONE.
REQ-018 Access types: MEMRD = mreq_n=0 & rd_n=0 & rfsh_n=1; MEMWR = mreq_n=0 & wr_n=0; IORD = iorq_n=0 & rd_n=0 & m1_n=1; IOWR = iorq_n=0 & wr_n=0; INTA = iorq_n=0 & m1_n=0.
REQ-019 Refresh (mreq_n=0 & rfsh_n=0 & rd_n=1 & wr_n=1) SHALL produce no request and no wait.
REQ-020 In IDLE, any access type except INTA SHALL latch address, type and cpu_do, then go to REQ with mem_req=1 on the next cycle.
REQ-021 mem_addr SHALL be cpu_a for memory cycles and {IO_PAGE, cpu_a[7:0]} for I/O cycles.
REQ-022 INTA in IDLE SHALL go directly to DONE with cpu_di=INTA_VEC, no mem_req, no wait.
REQ-023 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL be stable until the mem_ack cycle.
REQ-024 On mem_ack in REQ: mem_rdata SHALL be latched for reads and mem_req SHALL drop next cycle. The FSM SHALL then go to DONE if EXTRA_WAIT=0, else to XWAIT.
REQ-025 XWAIT SHALL count EXTRA_WAIT cycles, then go to DONE.
REQ-026 cpu_wait_n SHALL be combinational: 0 whenever a non-INTA, non-refresh access type is active and state is not DONE; 1 otherwise.
REQ-027 Latency: access seen at edge N gives mem_req=1 at N+1. Ack at edge M gives cpu_wait_n=1 from M+1+EXTRA_WAIT.
REQ-028 cpu_di SHALL hold the latched read byte (or INTA_VEC) from DONE entry until the next latch; it SHALL be 8'hFF after reset.
REQ-029 DONE SHALL return to IDLE when rd_n=1 & wr_n=1, or when mreq_n=1 & iorq_n=1. No new access SHALL start in the same cycle.
REQ-030 If strobes deassert while in REQ/XWAIT, the request SHALL complete normally (no cancel), then the FSM SHALL go to IDLE without entering DONE.
REQ-031 Rd to wr transition within one held mreq (no strobe release) SHALL NOT start a second access.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_di=8'hFF and wait counter=0.
REQ-033 Reset mid-access SHALL abandon it; a mem_ack arriving after reset SHALL be ignored.
REQ-034 After reset, cpu_wait_n SHALL follow REQ-026 with state IDLE.

Verification
REQ-035 MEMRD A=16'h43F7, ack after 3 cycles, rdata=8'hE9 -> mem_addr=16'h43F7, mem_we=0, cpu_wait_n low 4 cycles, cpu_di=8'hE9.
REQ-036 IOWR A=16'hAB55, cpu_do=8'h5A, immediate ack -> mem_addr=16'h1055, mem_we=1, mem_wdata=8'h5A, exactly one mem_req.
REQ-037 EXTRA_WAIT=2, MEMRD with immediate ack -> cpu_wait_n rises 3 cycles after the ack cycle.
REQ-038 Refresh cycle, then INTA -> no mem_req for either, cpu_wait_n=1 throughout, cpu_di=8'hFF during INTA.
REQ-039 reset_n=0 while in REQ, then late mem_ack -> mem_req=0 next edge, state IDLE, cpu_di=8'hFF, ack ignored.
REQ-040 Back-to-back M1 fetches with strobe release between -> two requests, addresses 16'h0000 then 16'h0001, one request per strobe assertion.
